rat_in_maze_gen: RTL and testbench

//  Parametrised DFS maze solver: grid of 2^COORD_W x 2^COORD_W cells held in an external
//  1-bit wall memory. Start/goal coordinates are runtime inputs. An internal move stack

---
 rtl/rat_in_maze_gen_if.sv | 40 ++++
 rtl/rat_in_maze_gen.sv | 186 ++++++++++++++++++
 tb/tb_rat_in_maze_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rat_in_maze_gen_if.sv
// Command, status, replay and wall-memory signals of the DFS maze solver.
// The solver attaches through the slave modport; the controlling side uses master.
interface rat_in_maze_gen_if #(
    parameter int COORD_W     = 4,
    parameter int STACK_DEPTH = 256
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic                 start;
    logic                 run;
    logic [COORD_W-1:0]   start_x;
    logic [COORD_W-1:0]   start_y;
    logic [COORD_W-1:0]   goal_x;
    logic [COORD_W-1:0]   goal_y;
    logic                 mem_rd;
    logic [2*COORD_W-1:0] mem_addr;
    logic                 mem_dout;
    logic                 busy;
    logic                 done;
    logic                 fail;
    logic                 overflow;
    logic [COORD_W-1:0]   x_o;
    logic [COORD_W-1:0]   y_o;
    logic [SP_W-1:0]      path_len;
    logic [1:0]           move;
    logic                 move_valid;
    logic                 replay_done;

    modport master (
        output start, run, start_x, start_y, goal_x, goal_y, mem_dout,
        input  mem_rd, mem_addr, busy, done, fail, overflow, x_o, y_o,
               path_len, move, move_valid, replay_done
    );

    modport slave (
        input  start, run, start_x, start_y, goal_x, goal_y, mem_dout,
        output mem_rd, mem_addr, busy, done, fail, overflow, x_o, y_o,
               path_len, move, move_valid, replay_done
    );
endinterface

// File: rtl/rat_in_maze_gen.sv
// DFS maze solver over an external 1-bit wall memory, with a move stack that
// records the current path and can be replayed one move per cycle.
module rat_in_maze_gen #(
    parameter int COORD_W     = 4,
    parameter int STACK_DEPTH = 256
) (
    input logic              clk,
    input logic              rst,
    rat_in_maze_gen_if.slave bus
);
    localparam int CELLS = 1 << (2 * COORD_W);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [COORD_W-1:0] MAXC = '1;

    typedef enum logic [2:0] {IDLE, CHECK, WAIT, BACK, DONE, FAIL, REPLAY} state_t;
    state_t state, state_n;

    logic [COORD_W-1:0]   sx, sy, gx, gy, px, py, rx, ry;
    logic [2:0]           d;
    logic [SP_W-1:0]      sp, ri;
    logic [1:0]           stack [STACK_DEPTH];
    logic [CELLS-1:0]     visited;
    logic [2*COORD_W-1:0] addr_q;
    logic                 ovf;

    logic                 accept, probe, adv, push, pop, rp_start, rstep, ovf_set;
    logic [2*COORD_W-1:0] cand_xy, back_xy, rep_xy;
    logic                 cand_off;
    logic [1:0]           top, rmove;

    // Move encoding: 0=up(y-1) 1=right(x+1) 2=left(x-1) 3=down(y+1); 3-m is the reverse move.
    function automatic logic [2*COORD_W-1:0] step(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input logic [1:0] m);
        logic [COORD_W-1:0] nx, ny;
        nx = x;
        ny = y;
        case (m)
            2'd0:    ny = y - COORD_W'(1);
            2'd1:    nx = x + COORD_W'(1);
            2'd2:    nx = x - COORD_W'(1);
            default: ny = y + COORD_W'(1);
        endcase
        return {ny, nx};
    endfunction

    function automatic logic off_grid(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y,
                                      input logic [1:0] m);
        case (m)
            2'd0:    return y == '0;
            2'd1:    return x == MAXC;
            2'd2:    return x == '0;
            default: return y == MAXC;
        endcase
    endfunction

    assign cand_xy  = step(px, py, d[1:0]);
    assign cand_off = off_grid(px, py, d[1:0]);
    assign top      = stack[IX_W'(sp - SP_W'(1))];
    assign back_xy  = step(px, py, 2'd3 - top);
    assign rmove    = stack[ri[IX_W-1:0]];
    assign rep_xy   = step(rx, ry, rmove);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        probe    = 1'b0;
        adv      = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        rp_start = 1'b0;
        rstep    = 1'b0;
        ovf_set  = 1'b0;
        case (state)
            CHECK:
                if (d == 3'd4) state_n = BACK;
                else if (cand_off || visited[cand_xy]) adv = 1'b1;
                else begin
                    probe   = 1'b1;
                    state_n = WAIT;
                end
            WAIT:
                if (bus.mem_dout) begin
                    adv     = 1'b1;
                    state_n = CHECK;
                end else if (sp == SP_W'(STACK_DEPTH)) begin
                    ovf_set = 1'b1;
                    state_n = FAIL;
                end else begin
                    push    = 1'b1;
                    state_n = (cand_xy == {gy, gx}) ? DONE : CHECK;
                end
            BACK:
                if (sp == '0) state_n = FAIL;
                else begin
                    pop     = 1'b1;
                    state_n = CHECK;
                end
            DONE:
                if (bus.run) begin
                    rp_start = 1'b1;
                    state_n  = REPLAY;
                end
            REPLAY:
                if (ri == sp) state_n = DONE;
                else          rstep   = 1'b1;
            default: ;
        endcase
        // A new start outranks run when both arrive in DONE.
        if ((state == IDLE || state == DONE || state == FAIL) && bus.start) begin
            accept   = 1'b1;
            rp_start = 1'b0;
            state_n  = ({bus.start_y, bus.start_x} == {bus.goal_y, bus.goal_x}) ? DONE : CHECK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx <= '0; sy <= '0; gx <= '0; gy <= '0;
            px <= '0; py <= '0; rx <= '0; ry <= '0;
            d <= '0; sp <= '0; ri <= '0;
            visited <= '0;
            addr_q  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                sx <= bus.start_x; sy <= bus.start_y;
                gx <= bus.goal_x;  gy <= bus.goal_y;
                px <= bus.start_x; py <= bus.start_y;
                d  <= '0;
                sp <= '0;
                ovf <= 1'b0;
                visited <= '0;
                visited[{bus.start_y, bus.start_x}] <= 1'b1;
            end
            if (adv)   d <= d + 3'd1;
            if (probe) addr_q <= cand_xy;
            if (push) begin
                sp <= sp + SP_W'(1);
                {py, px} <= cand_xy;
                visited[cand_xy] <= 1'b1;
                d <= '0;
            end
            // Visited marks stay set on backtrack so dead ends are never re-explored.
            if (pop) begin
                sp <= sp - SP_W'(1);
                {py, px} <= back_xy;
                d <= {1'b0, top} + 3'd1;
            end
            if (ovf_set) ovf <= 1'b1;
            if (rp_start) begin
                ri <= '0;
                rx <= sx;
                ry <= sy;
            end
            if (rstep) begin
                ri <= ri + SP_W'(1);
                {ry, rx} <= rep_xy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack[sp[IX_W-1:0]] <= d[1:0];
    end

    assign bus.mem_rd      = probe;
    assign bus.mem_addr    = probe ? cand_xy : addr_q;
    assign bus.busy        = state inside {CHECK, WAIT, BACK};
    assign bus.done        = (state == DONE) || (state == REPLAY);
    assign bus.fail        = (state == FAIL);
    assign bus.overflow    = ovf;
    assign bus.path_len    = sp;
    assign bus.move_valid  = rstep;
    assign bus.move        = rstep ? rmove : 2'd0;
    assign bus.replay_done = (state == REPLAY) && (ri == sp);
    assign bus.x_o = rstep ? rep_xy[COORD_W-1:0] : ((state == REPLAY) ? rx : px);
    assign bus.y_o = rstep ? rep_xy[2*COORD_W-1:COORD_W] : ((state == REPLAY) ? ry : py);
endmodule

// File: tb/tb_rat_in_maze_gen.sv
// Directed bench for rat_in_maze_gen: three instances (4x4 deep stack, 4x4 two-entry
// stack, 16x16 default) each with its own wall memory answering one cycle after mem_rd.
module tb_rat_in_maze_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rat_in_maze_gen_if #(.COORD_W(2), .STACK_DEPTH(16))  bus_a ();
    rat_in_maze_gen_if #(.COORD_W(2), .STACK_DEPTH(2))   bus_b ();
    rat_in_maze_gen_if #(.COORD_W(4), .STACK_DEPTH(256)) bus_c ();

    rat_in_maze_gen #(.COORD_W(2), .STACK_DEPTH(16))  u_a (.clk(clk), .rst(rst), .bus(bus_a));
    rat_in_maze_gen #(.COORD_W(2), .STACK_DEPTH(2))   u_b (.clk(clk), .rst(rst), .bus(bus_b));
    rat_in_maze_gen #(.COORD_W(4), .STACK_DEPTH(256)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic [15:0]  wall_a = '0;
    logic [15:0]  wall_b = '0;
    logic [255:0] wall_c = '1;

    always @(posedge clk) begin
        bus_a.mem_dout <= bus_a.mem_rd & wall_a[bus_a.mem_addr];
        bus_b.mem_dout <= bus_b.mem_rd & wall_b[bus_b.mem_addr];
        bus_c.mem_dout <= bus_c.mem_rd & wall_c[bus_c.mem_addr];
    end

    int rd_a = 0;
    int rd_c = 0;
    always @(posedge bus_a.mem_rd) rd_a++;
    always @(posedge bus_c.mem_rd) rd_c++;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_mv [3] = '{1, 3, 3};
    int exp_x  [3] = '{1, 1, 1};
    int exp_y  [3] = '{0, 1, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        bus_a.start = 0; bus_a.run = 0; bus_a.start_x = 0; bus_a.start_y = 0; bus_a.goal_x = 0; bus_a.goal_y = 0;
        bus_b.start = 0; bus_b.run = 0; bus_b.start_x = 0; bus_b.start_y = 0; bus_b.goal_x = 0; bus_b.goal_y = 0;
        bus_c.start = 0; bus_c.run = 0; bus_c.start_x = 0; bus_c.start_y = 0; bus_c.goal_x = 0; bus_c.goal_y = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_fail", bus_a.fail, 0);
        chk("rst_len", bus_a.path_len, 0);
        chk("rst_memrd", bus_a.mem_rd, 0);
        chk("rst_x", bus_a.x_o, 0);
        chk("rst_c_len", bus_c.path_len, 0);
        chk("rst_c_valid", bus_c.move_valid, 0);
        rst = 1'b0;

        // open 4x4, (0,0) -> (3,0)
        @(negedge clk);
        bus_a.start_x = 0; bus_a.start_y = 0; bus_a.goal_x = 3; bus_a.goal_y = 0; bus_a.start = 1;
        @(negedge clk);
        bus_a.start = 0;
        chk("t1_busy", bus_a.busy, 1);
        cyc = 0;
        while (!bus_a.done && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t1_cycles", cyc, 9);
        chk("t1_len", bus_a.path_len, 3);
        chk("t1_x", bus_a.x_o, 3);
        chk("t1_busy_end", bus_a.busy, 0);
        bus_a.run = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus_a.run = 0;
            chk("t1_mv_valid", bus_a.move_valid, 1);
            chk("t1_mv", bus_a.move, 1);
            chk("t1_rx", bus_a.x_o, k);
            chk("t1_ry", bus_a.y_o, 0);
            chk("t1_rp_done_lvl", bus_a.done, 1);
        end
        @(negedge clk);
        chk("t1_rdone", bus_a.replay_done, 1);
        chk("t1_rdone_mv", bus_a.move_valid, 0);
        @(negedge clk);
        chk("t1_rdone_pulse", bus_a.replay_done, 0);
        chk("t1_done_after", bus_a.done, 1);

        // start == goal
        bus_a.start_x = 2; bus_a.start_y = 1; bus_a.goal_x = 2; bus_a.goal_y = 1; bus_a.start = 1;
        @(negedge clk);
        bus_a.start = 0;
        chk("t5_done", bus_a.done, 1);
        chk("t5_len", bus_a.path_len, 0);
        chk("t5_x", bus_a.x_o, 2);
        chk("t5_y", bus_a.y_o, 1);
        bus_a.run = 1;
        @(negedge clk);
        bus_a.run = 0;
        chk("t5_rdone", bus_a.replay_done, 1);
        chk("t5_mv_valid", bus_a.move_valid, 0);
        @(negedge clk);
        chk("t5_rdone_pulse", bus_a.replay_done, 0);
        chk("t5_done_after", bus_a.done, 1);

        // walled-in start
        wall_a = 16'h0012;
        base = rd_a;
        bus_a.start_x = 0; bus_a.start_y = 0; bus_a.goal_x = 3; bus_a.goal_y = 3; bus_a.start = 1;
        @(negedge clk);
        bus_a.start = 0;
        cyc = 0;
        while (!(bus_a.fail || bus_a.done) && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t2_fail", bus_a.fail, 1);
        chk("t2_done", bus_a.done, 0);
        chk("t2_ovf", bus_a.overflow, 0);
        chk("t2_len", bus_a.path_len, 0);
        chk("t2_rd_pulses", rd_a - base, 2);
        bus_a.run = 1;
        @(negedge clk);
        bus_a.run = 0;
        @(negedge clk);
        chk("t2_run_ignored_valid", bus_a.move_valid, 0);
        chk("t2_run_ignored_fail", bus_a.fail, 1);

        // stack overflow with a two-entry stack
        bus_b.start_x = 0; bus_b.start_y = 0; bus_b.goal_x = 3; bus_b.goal_y = 0; bus_b.start = 1;
        @(negedge clk);
        bus_b.start = 0;
        cyc = 0;
        while (!(bus_b.fail || bus_b.done) && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t3_fail", bus_b.fail, 1);
        chk("t3_ovf", bus_b.overflow, 1);
        chk("t3_len", bus_b.path_len, 2);
        chk("t3_done", bus_b.done, 0);
        chk("t3_x", bus_b.x_o, 2);

        // 16x16 corridor with dead end at (2,0); goal (1,2)
        wall_c[0] = 0; wall_c[1] = 0; wall_c[2] = 0; wall_c[17] = 0; wall_c[33] = 0;
        base = rd_c;
        bus_c.start_x = 0; bus_c.start_y = 0; bus_c.goal_x = 1; bus_c.goal_y = 2; bus_c.start = 1;
        @(negedge clk);
        bus_c.start = 0;
        cyc = 0;
        while (!(bus_c.done || bus_c.fail) && cyc < 300) begin @(negedge clk); cyc++; end
        chk("t4_done", bus_c.done, 1);
        chk("t4_cycles", cyc, 24);
        chk("t4_rd_pulses", rd_c - base, 8);
        chk("t4_len", bus_c.path_len, 3);
        chk("t4_x", bus_c.x_o, 1);
        chk("t4_y", bus_c.y_o, 2);
        bus_c.run = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_c.run = 0;
            chk("t4_mv_valid", bus_c.move_valid, 1);
            chk("t4_mv", bus_c.move, exp_mv[k]);
            chk("t4_rx", bus_c.x_o, exp_x[k]);
            chk("t4_ry", bus_c.y_o, exp_y[k]);
        end
        @(negedge clk);
        chk("t4_rdone", bus_c.replay_done, 1);

        // asynchronous reset mid-solve, then a fresh solve with an ignored start while busy
        wall_a = '0;
        bus_a.start_x = 0; bus_a.start_y = 0; bus_a.goal_x = 3; bus_a.goal_y = 3; bus_a.start = 1;
        @(negedge clk);
        bus_a.start = 0;
        cyc = 0;
        while (bus_a.path_len != 2 && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t6_mid_len", bus_a.path_len, 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", bus_a.busy, 0);
        chk("t6_rst_len", bus_a.path_len, 0);
        chk("t6_rst_x", bus_a.x_o, 0);
        chk("t6_rst_addr", bus_a.mem_addr, 0);
        chk("t6_rst_done", bus_a.done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_a.start_x = 3; bus_a.start_y = 3; bus_a.goal_x = 3; bus_a.goal_y = 0; bus_a.start = 1;
        @(negedge clk);
        chk("t6_busy", bus_a.busy, 1);
        bus_a.start_x = 0; bus_a.start_y = 0; bus_a.goal_x = 0; bus_a.goal_y = 0;
        @(negedge clk);
        bus_a.start = 0;
        cyc = 0;
        while (!(bus_a.done || bus_a.fail) && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t6_done", bus_a.done, 1);
        chk("t6_len", bus_a.path_len, 3);
        chk("t6_x", bus_a.x_o, 3);
        chk("t6_y", bus_a.y_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
